// File: rtl/fifo_pkg.sv
// Shared constants and types for the pointer-based FIFO status logic.
package fifo_pkg;

  localparam int ADDR_W = 9;
  localparam int PTR_W  = ADDR_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    WM_LOW  = 2'b00,
    WM_MID  = 2'b01,
    WM_HIGH = 2'b10
  } wm_state_e;

  // Occupancy from wrap-bit pointers; modular subtraction handles wrap.
  function automatic logic [PTR_W-1:0] fifo_level(input logic [PTR_W-1:0] wptr,
                                                  input logic [PTR_W-1:0] rptr);
    return wptr - rptr;
  endfunction

endpackage

// File: rtl/fifo_watermark_fsm.sv
// Almost-full / almost-empty watermarks with hysteresis.
//
//   state | meaning
//   LOW   | level at or below AE_THR, not yet above AE_THR+HYST (almost empty)
//   MID   | between the two watermark bands
//   HIGH  | level at or above AF_THR, not yet below AF_THR-HYST (almost full)
//   2'b11 | unused, recovers to LOW
module fifo_watermark_fsm
  import fifo_pkg::*;
#(
  parameter int AF_THR = 480,
  parameter int AE_THR = 32,
  parameter int HYST   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PTR_W-1:0] level_i,
  output logic             almost_full_o,
  output logic             almost_empty_o
);

  localparam logic [1:0] S_LOW  = WM_LOW;
  localparam logic [1:0] S_MID  = WM_MID;
  localparam logic [1:0] S_HIGH = WM_HIGH;

  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THR);
  localparam logic [PTR_W-1:0] AE_REL = PTR_W'(AE_THR + HYST);
  localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THR);
  localparam logic [PTR_W-1:0] AF_REL = PTR_W'(AF_THR - HYST);

  logic [1:0] state_q, state_d;

  // Next state: hard thresholds first, hysteresis band only inside them.
  always_comb begin
    state_d = S_LOW;
    if (level_i <= AE_LVL) begin
      state_d = S_LOW;
    end else if (level_i >= AF_LVL) begin
      state_d = S_HIGH;
    end else begin
      case (state_q)
        S_LOW:   state_d = (level_i > AE_REL) ? S_MID : S_LOW;
        S_HIGH:  state_d = (level_i < AF_REL) ? S_MID : S_HIGH;
        S_MID:   state_d = S_MID;
        default: state_d = S_LOW;
      endcase
    end
  end

  // State register; reset lands in LOW since an empty FIFO is almost empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_LOW;
    else        state_q <= state_d;
  end

  assign almost_empty_o = (state_q == S_LOW);
  assign almost_full_o  = (state_q == S_HIGH);

endmodule

// File: rtl/fifo_status.sv
// FIFO status stage: full/empty/level from pointers, watermarks,
// sticky overflow/underflow and high-water mark.
module fifo_status
  import fifo_pkg::*;
#(
  parameter int AF_THR = 480,
  parameter int AE_THR = 32,
  parameter int HYST   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [PTR_W-1:0] wptr_i,
  input  logic [PTR_W-1:0] rptr_i,
  input  logic             clr_sticky_i,
  output logic             fifo_full_o,
  output logic             fifo_empty_o,
  output logic             fifo_almost_full_o,
  output logic             fifo_almost_empty_o,
  output logic             fifo_overflow_o,
  output logic             fifo_underflow_o,
  output logic [PTR_W-1:0] fifo_level_o,
  output logic [PTR_W-1:0] fifo_hwm_o
);

  generate
    if ((AE_THR + HYST >= AF_THR - HYST) || (AF_THR > DEPTH)) begin : g_bad_params
      $error("fifo_status: watermark thresholds overlap or exceed DEPTH");
    end
  endgenerate

  logic [PTR_W-1:0] level;
  logic             full, empty;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [PTR_W-1:0] hwm_q, hwm_d;

  assign level = fifo_level(wptr_i, rptr_i);
  assign empty = (wptr_i == rptr_i);
  assign full  = (wptr_i[PTR_W-1] != rptr_i[PTR_W-1]) &&
                 (wptr_i[ADDR_W-1:0] == rptr_i[ADDR_W-1:0]);

  // Sticky error flags and high-water mark; a new error wins over a clear.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    hwm_d = hwm_q;
    if (wr_i && full)      ovf_d = 1'b1;
    else if (clr_sticky_i) ovf_d = 1'b0;
    if (rd_i && empty)     unf_d = 1'b1;
    else if (clr_sticky_i) unf_d = 1'b0;
    if (clr_sticky_i)      hwm_d = level;
    else if (level > hwm_q) hwm_d = level;
  end

  // Status registers, survive pointer resets; only rst_n/clr_sticky clear them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      hwm_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      hwm_q <= hwm_d;
    end
  end

  fifo_watermark_fsm #(
    .AF_THR (AF_THR),
    .AE_THR (AE_THR),
    .HYST   (HYST)
  ) u_wm (
    .clk            (clk),
    .rst_n          (rst_n),
    .level_i        (level),
    .almost_full_o  (fifo_almost_full_o),
    .almost_empty_o (fifo_almost_empty_o)
  );

  assign fifo_full_o      = full;
  assign fifo_empty_o     = empty;
  assign fifo_level_o     = level;
  assign fifo_overflow_o  = ovf_q;
  assign fifo_underflow_o = unf_q;
  assign fifo_hwm_o       = hwm_q;

endmodule

// File: tb/tb_fifo_status.sv
// Directed bench for fifo_status.
module tb_fifo_status;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr, rd, clr;
  logic [9:0] wptr, rptr;
  logic       full, empty, af, ae, ovf, unf;
  logic [9:0] lvl, hwm;

  int n_vec = 0;
  int n_err = 0;

  fifo_status dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .wr_i                (wr),
    .rd_i                (rd),
    .wptr_i              (wptr),
    .rptr_i              (rptr),
    .clr_sticky_i        (clr),
    .fifo_full_o         (full),
    .fifo_empty_o        (empty),
    .fifo_almost_full_o  (af),
    .fifo_almost_empty_o (ae),
    .fifo_overflow_o     (ovf),
    .fifo_underflow_o    (unf),
    .fifo_level_o        (lvl),
    .fifo_hwm_o          (hwm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr = 0; rd = 0; clr = 0; wptr = 0; rptr = 0;
    #3;
    n_vec++;
    if ({empty, full, ae, af, ovf, unf} !== 6'b101000) begin
      n_err++; $display("FAIL reset_flags: got e/f/ae/af/ovf/unf=%b want 101000",
                        {empty, full, ae, af, ovf, unf});
    end
    n_vec++;
    if (lvl !== 10'd0 || hwm !== 10'd0) begin
      n_err++; $display("FAIL reset_counts: got lvl=%0d hwm=%0d want 0/0", lvl, hwm);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i <= 512; i++) begin
      wptr = 10'(i);
      #1;
      n_vec++;
      if (lvl !== 10'(i) || full !== (i == 512) || empty !== (i == 0)) begin
        n_err++; $display("FAIL fill_comb i=%0d: got lvl=%0d full=%b empty=%b want lvl=%0d full=%b empty=%b",
                          i, lvl, full, empty, i, (i == 512), (i == 0));
      end
      tick();
      n_vec++;
      if (af !== (i >= 480) || ae !== (i <= 40) || hwm !== 10'(i)) begin
        n_err++; $display("FAIL fill_reg i=%0d: got af=%b ae=%b hwm=%0d want af=%b ae=%b hwm=%0d",
                          i, af, ae, hwm, (i >= 480), (i <= 40), i);
      end
    end
  endtask

  task automatic test_overflow();
    wr = 1; tick(); wr = 0;
    n_vec++;
    if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", ovf); end
    tick();
    n_vec++;
    if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_hold: got %b want 1", ovf); end
    wr = 1; clr = 1; tick();
    n_vec++;
    if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set_beats_clr: got %b want 1", ovf); end
    wr = 0; tick(); clr = 0;
    n_vec++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", ovf); end
  endtask

  task automatic test_underflow();
    rptr = 10'h200;
    #1;
    n_vec++;
    if (empty !== 1'b1 || lvl !== 10'd0) begin
      n_err++; $display("FAIL unf_empty: got empty=%b lvl=%0d want 1/0", empty, lvl);
    end
    rd = 1; tick(); rd = 0;
    n_vec++;
    if (unf !== 1'b1 || hwm !== 10'd512 || ae !== 1'b1 || af !== 1'b0) begin
      n_err++; $display("FAIL unf_set: got unf=%b hwm=%0d ae=%b af=%b want 1/512/1/0", unf, hwm, ae, af);
    end
    wptr = 10'h20A; clr = 1; tick(); clr = 0;
    n_vec++;
    if (unf !== 1'b0 || hwm !== 10'd10) begin
      n_err++; $display("FAIL unf_clr: got unf=%b hwm=%0d want 0/10", unf, hwm);
    end
  endtask

  task automatic test_hysteresis();
    // Each row: level applied for one edge, expected af, ae afterwards.
    int unsigned lv [9]  = '{480, 473, 472, 471, 100, 32, 40, 41, 32};
    logic        eaf [9] = '{1,   1,   1,   0,   0,   0,  0,  0,  0};
    logic        eae [9] = '{0,   0,   0,   0,   0,   1,  1,  0,  1};
    rptr = 10'd0;
    for (int k = 0; k < 9; k++) begin
      wptr = 10'(lv[k]);
      tick();
      n_vec++;
      if (af !== eaf[k] || ae !== eae[k]) begin
        n_err++; $display("FAIL hyst lvl=%0d: got af=%b ae=%b want af=%b ae=%b",
                          lv[k], af, ae, eaf[k], eae[k]);
      end
    end
    n_vec++;
    if (hwm !== 10'd480) begin n_err++; $display("FAIL hyst_hwm: got %0d want 480", hwm); end
  endtask

  task automatic test_wrap_reset();
    wptr = 10'h005; rptr = 10'h3FD;
    #1;
    n_vec++;
    if (lvl !== 10'd8 || empty !== 1'b0 || full !== 1'b0) begin
      n_err++; $display("FAIL wrap_lvl: got lvl=%0d empty=%b full=%b want 8/0/0", lvl, empty, full);
    end
    tick();
    wptr = 10'h105; rptr = 10'h305;
    #1;
    n_vec++;
    if (full !== 1'b1 || lvl !== 10'd512) begin
      n_err++; $display("FAIL wrap_full: got full=%b lvl=%0d want 1/512", full, lvl);
    end
    wr = 1; tick(); wr = 0;
    n_vec++;
    if (af !== 1'b1 || ae !== 1'b0 || ovf !== 1'b1 || hwm !== 10'd512) begin
      n_err++; $display("FAIL wrap_high: got af=%b ae=%b ovf=%b hwm=%0d want 1/0/1/512", af, ae, ovf, hwm);
    end
    // Pointer reset mid-operation: flags follow immediately, state next edge.
    wptr = 10'd0; rptr = 10'd0;
    #1;
    n_vec++;
    if (empty !== 1'b1 || af !== 1'b1) begin
      n_err++; $display("FAIL ptr_rst_comb: got empty=%b af=%b want 1/1", empty, af);
    end
    tick();
    n_vec++;
    if (af !== 1'b0 || ae !== 1'b1 || ovf !== 1'b1 || hwm !== 10'd512) begin
      n_err++; $display("FAIL ptr_rst_reg: got af=%b ae=%b ovf=%b hwm=%0d want 0/1/1/512", af, ae, ovf, hwm);
    end
    wptr = 10'h200;
    tick();
    n_vec++;
    if (af !== 1'b1) begin n_err++; $display("FAIL rehigh: got af=%b want 1", af); end
    // Async reset between edges.
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (af !== 1'b0 || ae !== 1'b1 || ovf !== 1'b0 || unf !== 1'b0 || hwm !== 10'd0) begin
      n_err++; $display("FAIL async_rst: got af=%b ae=%b ovf=%b unf=%b hwm=%0d want 0/1/0/0/0",
                        af, ae, ovf, unf, hwm);
    end
    n_vec++;
    if (full !== 1'b1 || lvl !== 10'd512) begin
      n_err++; $display("FAIL async_rst_comb: got full=%b lvl=%0d want 1/512", full, lvl);
    end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_hysteresis();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
